// File: rtl/regbank_spill_if.sv
// Wishbone-classic bus bundle between the spill engine and memory.
// The master drives the request, the slave returns data and acknowledge.
interface regbank_spill_if #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [AWIDTH-1:0] adr;
    logic [WIDTH-1:0]  dat_o;
    logic [WIDTH-1:0]  dat_i;
    logic              ack;

    modport master (
        output cyc, stb, we, adr, dat_o,
        input  dat_i, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_o,
        output dat_i, ack
    );
endinterface

// File: rtl/regbank_spill.sv
// Banked register save/restore engine: spills one bank of the register
// file to memory, or fills it back from memory, over a Wishbone master.
module regbank_spill #(
    parameter int WIDTH  = 32,
    parameter int WINP   = 4,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [3:0]        bank_i,
    input  logic [AWIDTH-1:0] base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        rf_bank_o,
    output logic [WINP-1:0]   rf_read_o,
    input  logic [WIDTH-1:0]  rf_data_i,
    output logic [WINP-1:0]   rf_write_addr_o,
    output logic [WIDTH-1:0]  rf_write_data_o,
    output logic [1:0]        rf_write_en_o,
    regbank_spill_if.master   bus
);

    localparam int IW = WINP - 1;
    localparam logic [IW-1:0] LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        SP_RD,
        SP_BUS,
        FL_BUS,
        FL_WR,
        DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nx;
    logic [AWIDTH-1:0] base_q;

    assign idx_nx = idx + IW'(1);

    function automatic logic [AWIDTH-1:0] adr_of(
        input logic [AWIDTH-1:0] b,
        input logic [IW-1:0]     i
    );
        return b + (AWIDTH'(i) << 2);
    endfunction

    // Sequencer: every output is a register set on the transition into
    // the state that presents it, so reset clears the bus at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            idx             <= '0;
            base_q          <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            rf_bank_o       <= '0;
            rf_read_o       <= '0;
            rf_write_addr_o <= '0;
            rf_write_data_o <= '0;
            rf_write_en_o   <= 2'b00;
            bus.cyc         <= 1'b0;
            bus.stb         <= 1'b0;
            bus.we          <= 1'b0;
            bus.adr         <= '0;
            bus.dat_o       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        idx       <= '0;
                        base_q    <= base_i;
                        rf_bank_o <= bank_i;
                        busy_o    <= 1'b1;
                        if (op_i) begin
                            bus.cyc <= 1'b1;
                            bus.stb <= 1'b1;
                            bus.we  <= 1'b0;
                            bus.adr <= base_i;
                            state   <= FL_BUS;
                        end else begin
                            rf_read_o <= {1'b1, IW'(0)};
                            state     <= SP_RD;
                        end
                    end
                end
                SP_RD: begin
                    bus.dat_o <= rf_data_i;
                    bus.adr   <= adr_of(base_q, idx);
                    bus.cyc   <= 1'b1;
                    bus.stb   <= 1'b1;
                    bus.we    <= 1'b1;
                    state     <= SP_BUS;
                end
                SP_BUS: begin
                    if (bus.ack) begin
                        bus.cyc <= 1'b0;
                        bus.stb <= 1'b0;
                        bus.we  <= 1'b0;
                        if (idx == LAST) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx       <= idx_nx;
                            rf_read_o <= {1'b1, idx_nx};
                            state     <= SP_RD;
                        end
                    end
                end
                FL_BUS: begin
                    if (bus.ack) begin
                        bus.cyc         <= 1'b0;
                        bus.stb         <= 1'b0;
                        rf_write_data_o <= bus.dat_i;
                        rf_write_addr_o <= {1'b1, idx};
                        rf_write_en_o   <= 2'b11;
                        state           <= FL_WR;
                    end
                end
                FL_WR: begin
                    rf_write_en_o <= 2'b00;
                    if (idx == LAST) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx     <= idx_nx;
                        bus.cyc <= 1'b1;
                        bus.stb <= 1'b1;
                        bus.adr <= adr_of(base_q, idx_nx);
                        state   <= FL_BUS;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_spill.sv
// Scoreboard bench for regbank_spill: a Wishbone slave model and a
// register-file write monitor compare DUT traffic with queued expectations.
module tb_regbank_spill;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        op_i;
    logic [3:0]  bank_i;
    logic [31:0] base_i;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  rf_bank_o;
    logic [3:0]  rf_read_o;
    logic [31:0] rf_data_i;
    logic [3:0]  rf_write_addr_o;
    logic [31:0] rf_write_data_o;
    logic [1:0]  rf_write_en_o;

    regbank_spill_if #(.WIDTH(32), .AWIDTH(32)) bus ();

    regbank_spill #(.WIDTH(32), .WINP(4), .AWIDTH(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .op_i            (op_i),
        .bank_i          (bank_i),
        .base_i          (base_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .rf_bank_o       (rf_bank_o),
        .rf_read_o       (rf_read_o),
        .rf_data_i       (rf_data_i),
        .rf_write_addr_o (rf_write_addr_o),
        .rf_write_data_o (rf_write_data_o),
        .rf_write_en_o   (rf_write_en_o),
        .bus             (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } exp_t;

    exp_t        exp_sp[$];
    exp_t        exp_rf[$];
    logic [31:0] rf_mem [16][16];
    int          total = 0;
    int          bad = 0;
    int          waits = 0;
    bit          stray_ack = 0;
    int          wr_cnt = 0;
    logic [31:0] fill_seed = 0;
    logic [31:0] fill_base = 0;

    assign rf_data_i = rf_mem[rf_bank_o][rf_read_o];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wishbone slave: optional wait states, scoreboarded spill writes,
    // patterned fill data, optional stray acks while the bus is idle.
    task automatic slave_loop();
        int          wc = 0;
        bit          inx = 0;
        logic [31:0] a0 = 0;
        logic [31:0] d0 = 0;
        logic        w0 = 0;
        exp_t        e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                bus.ack = 1'b0;
                inx = 0;
            end else if (bus.cyc && bus.stb) begin
                if (!inx) begin
                    inx = 1;
                    wc = 0;
                    a0 = bus.adr;
                    d0 = bus.dat_o;
                    w0 = bus.we;
                end else begin
                    check("hold_adr", bus.adr, a0);
                    check("hold_dat", bus.dat_o, d0);
                    check("hold_we", bus.we, w0);
                end
                if (wc >= waits) begin
                    bus.ack = 1'b1;
                    inx = 0;
                    if (bus.we) begin
                        if (exp_sp.size() == 0) begin
                            check("sp_extra", 1, 0);
                        end else begin
                            e = exp_sp.pop_front();
                            check("sp_adr", bus.adr, e.a);
                            check("sp_dat", bus.dat_o, e.d);
                        end
                    end else begin
                        bus.dat_i = fill_seed
                                  + ((bus.adr - fill_base) >> 2);
                    end
                end else begin
                    bus.ack = 1'b0;
                    wc++;
                end
            end else begin
                bus.ack = stray_ack;
                inx = 0;
            end
        end
    endtask

    // Register-file write monitor: every write must match the next
    // expected fill entry; any write with nothing expected is an error.
    task automatic rf_mon();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rf_write_en_o != 2'b00) begin
                wr_cnt++;
                if (exp_rf.size() == 0) begin
                    check("rf_extra", 1, 0);
                end else begin
                    e = exp_rf.pop_front();
                    check("rf_en", rf_write_en_o, 2'b11);
                    check("rf_addr", rf_write_addr_o, e.a);
                    check("rf_data", rf_write_data_o, e.d);
                    check("rf_bank", rf_bank_o, e.b);
                end
            end
        end
    endtask

    task automatic load(input bit op, input logic [3:0] bk,
                        input logic [31:0] base, input logic [31:0] seed);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = bk;
            e.d = seed + 32'(i);
            if (op) begin
                e.a = 32'(8 + i);
                exp_rf.push_back(e);
            end else begin
                rf_mem[bk][8 + i] = seed + 32'(i);
                e.a = base + 32'(4 * i);
                exp_sp.push_back(e);
            end
        end
        if (op) begin
            fill_seed = seed;
            fill_base = base;
        end
    endtask

    task automatic run(input bit op, input logic [3:0] bk,
                       input logic [31:0] base, input logic [31:0] seed,
                       input int w, input int exp_cyc, input bit poke);
        int n = 0;
        bit got = 0;
        waits = w;
        load(op, bk, base, seed);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i = op;
        bank_i = bk;
        base_i = base;
        while (n < 300 && !got) begin
            @(negedge clk_i);
            n++;
            start_i = poke && (n == 5);
            if (poke && n == 5) begin
                op_i = 1'b1;
                bank_i = 4'hF;
                base_i = 32'hDEAD_0000;
            end
            if (done_o) got = 1;
        end
        check("done_cyc", n, exp_cyc);
        check("busy_in_done", busy_o, 1);
        check("bank_hold", rf_bank_o, bk);
        @(negedge clk_i);
        check("done_pulse", done_o, 0);
        check("busy_end", busy_o, 0);
        check("sp_left", exp_sp.size(), 0);
        check("rf_left", exp_rf.size(), 0);
        start_i = 1'b0;
    endtask

    initial begin
        int n;
        for (int b = 0; b < 16; b++)
            for (int r = 0; r < 16; r++)
                rf_mem[b][r] = 32'h5500_0000 | 32'(b * 16 + r);
        rst_ni = 1'b0;
        start_i = 1'b0;
        op_i = 1'b0;
        bank_i = 4'h0;
        base_i = 32'h0;
        bus.ack = 1'b0;
        bus.dat_i = 32'h0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cyc", bus.cyc, 0);
        check("rst_stb", bus.stb, 0);
        check("rst_we", bus.we, 0);
        check("rst_en", rf_write_en_o, 0);
        check("rst_adr", bus.adr, 0);
        check("rst_bank", rf_bank_o, 0);
        fork
            slave_loop();
            rf_mon();
        join_none
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run(0, 4'd2, 32'h0000_1000, 32'hA0, 0, 17, 0);
        run(1, 4'd5, 32'h0000_2000, 32'hB0, 0, 17, 0);
        run(0, 4'd3, 32'h0000_3000, 32'hD0, 3, 41, 0);
        run(0, 4'd1, 32'hFFFF_FFF8, 32'hC0, 0, 17, 0);
        stray_ack = 1;
        run(0, 4'd2, 32'h0000_1000, 32'hA0, 0, 17, 1);
        stray_ack = 0;
        run(1, 4'd9, 32'h0000_4000, 32'hE0, 1, 25, 0);

        wr_cnt = 0;
        waits = 2;
        load(1, 4'd6, 32'h0000_5000, 32'h60);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i = 1'b1;
        bank_i = 4'd6;
        base_i = 32'h0000_5000;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (n < 100 && wr_cnt < 3) begin
            @(negedge clk_i);
            n++;
        end
        check("partial_wr", wr_cnt, 3);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_busy", busy_o, 0);
        check("mid_done", done_o, 0);
        check("mid_cyc", bus.cyc, 0);
        check("mid_stb", bus.stb, 0);
        check("mid_en", rf_write_en_o, 0);
        check("mid_bank", rf_bank_o, 0);
        exp_rf.delete();
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        check("after_rst_wr", wr_cnt, 3);
        run(0, 4'd7, 32'h0000_6000, 32'h70, 0, 17, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
